// File: rtl/cdiv_pkg.sv
// rtl/cdiv_pkg.sv - shared types and constants for the iterative complex divider
// Purpose: operand/quotient types, FSM state encoding and the iteration count
//          helper used by complex_div_seq and its bench.
// Ports: none (package).
package cdiv_pkg;

   localparam int CDIV_WIDTH = 16;

   typedef struct packed {
      logic signed [CDIV_WIDTH-1:0] re;
      logic signed [CDIV_WIDTH-1:0] im;
   } cplx_in_t;

   typedef logic signed [2*CDIV_WIDTH:0] cplx_q_t;

   typedef enum logic [1:0] {
      IDLE,
      PREP,
      DIV,
      DONE
   } cdiv_state_e;

   // One restoring step per bit of |N|, which is 2*width+1 bits wide.
   function automatic int cdiv_iter(input int width);
      return 2 * width + 1;
   endfunction

   localparam int ITER = cdiv_iter(CDIV_WIDTH);

endpackage

// File: rtl/cdiv_serial_step.sv
// rtl/cdiv_serial_step.sv - one unsigned restoring divider, one quotient bit per cycle
// Purpose: holds the partial remainder and a shift register that starts as the
//          dividend and fills with quotient bits from the LSB end.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   load               capture dividend, clear remainder
//   step               perform one shift/subtract step
//   dividend [NW-1:0]  unsigned dividend, sampled on load
//   divisor  [DW-1:0]  unsigned divisor, must be stable while stepping
//   quot_next[NW-1:0]  shift register contents after the current step
module cdiv_serial_step #(
   parameter int NW = 33,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          step,
   input  logic [NW-1:0] dividend,
   input  logic [DW-1:0] divisor,
   output logic [NW-1:0] quot_next
);

   logic [DW-1:0] rem_q, rem_d;
   logic [NW-1:0] sh_q, sh_d;
   logic [DW:0]   rem_sh;
   logic          ge;

   always_comb begin
      // Remainder stays below the divisor, so the shifted value fits DW+1 bits.
      rem_sh    = {rem_q, sh_q[NW-1]};
      ge        = (rem_sh >= {1'b0, divisor});
      quot_next = {sh_q[NW-2:0], ge};
      rem_d     = rem_q;
      sh_d      = sh_q;
      if (load) begin
         rem_d = '0;
         sh_d  = dividend;
      end else if (step) begin
         rem_d = ge ? DW'(rem_sh - {1'b0, divisor}) : rem_sh[DW-1:0];
         sh_d  = quot_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= '0;
         sh_q  <= '0;
      end else begin
         rem_q <= rem_d;
         sh_q  <= sh_d;
      end
   end

endmodule

// File: rtl/complex_div_seq.sv
// rtl/complex_div_seq.sv - iterative complex divider q = a / c, truncating toward zero
// Purpose: computes N = a * conj(c) and D = |c|^2, then divides |N_re| and |N_im|
//          by D with two serial restoring dividers and restores the signs.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake (a_re, a_im, c_re, c_im)
//   out_valid/out_ready      result handshake (q_re, q_im, div_zero)
//   q_re, q_im [2W:0]        signed quotient parts
//   div_zero                 divisor was 0+0j (qualified by out_valid)
module complex_div_seq
   import cdiv_pkg::*;
#(
   parameter int WIDTH = CDIV_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [WIDTH-1:0] a_re,
   input  logic signed [WIDTH-1:0] a_im,
   input  logic signed [WIDTH-1:0] c_re,
   input  logic signed [WIDTH-1:0] c_im,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [2*WIDTH:0] q_re,
   output logic signed [2*WIDTH:0] q_im,
   output logic                   div_zero
);

   localparam int NW    = 2 * WIDTH + 1;
   localparam int DW    = 2 * WIDTH;
   localparam int NITER = cdiv_iter(WIDTH);
   localparam int CW    = $clog2(NITER + 1);

   cdiv_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic signed [WIDTH-1:0] ar_q, ar_d, ai_q, ai_d, cr_q, cr_d, ci_q, ci_d;
   logic [DW-1:0] d_q, d_d;
   logic neg_re_q, neg_re_d, neg_im_q, neg_im_d;
   logic signed [NW-1:0] q_re_q, q_re_d, q_im_q, q_im_d;
   logic dz_q, dz_d;

   // Operands sign-extended to NW so products and sums never overflow.
   logic signed [NW-1:0] ar_x, ai_x, cr_x, ci_x;
   logic signed [NW-1:0] n_re, n_im, d_full;
   logic [DW-1:0]        d_now;
   logic [NW-1:0]        n_re_abs, n_im_abs, quo_re, quo_im;

   assign ar_x     = NW'(ar_q);
   assign ai_x     = NW'(ai_q);
   assign cr_x     = NW'(cr_q);
   assign ci_x     = NW'(ci_q);
   assign n_re     = ar_x * cr_x + ai_x * ci_x;
   assign n_im     = ai_x * cr_x - ar_x * ci_x;
   assign d_full   = cr_x * cr_x + ci_x * ci_x;
   assign d_now    = DW'(d_full);
   assign n_re_abs = n_re[NW-1] ? NW'(-n_re) : n_re;
   assign n_im_abs = n_im[NW-1] ? NW'(-n_im) : n_im;

   cdiv_serial_step #(.NW(NW), .DW(DW)) u_div_re (
      .clk       (clk),
      .rst       (rst),
      .load      (state_q == PREP),
      .step      (state_q == DIV),
      .dividend  (n_re_abs),
      .divisor   (d_q),
      .quot_next (quo_re)
   );

   cdiv_serial_step #(.NW(NW), .DW(DW)) u_div_im (
      .clk       (clk),
      .rst       (rst),
      .load      (state_q == PREP),
      .step      (state_q == DIV),
      .dividend  (n_im_abs),
      .divisor   (d_q),
      .quot_next (quo_im)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ar_d      = ar_q;
      ai_d      = ai_q;
      cr_d      = cr_q;
      ci_d      = ci_q;
      d_d       = d_q;
      neg_re_d  = neg_re_q;
      neg_im_d  = neg_im_q;
      q_re_d    = q_re_q;
      q_im_d    = q_im_q;
      dz_d      = dz_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               ar_d    = a_re;
               ai_d    = a_im;
               cr_d    = c_re;
               ci_d    = c_im;
               state_d = PREP;
            end
         end
         PREP: begin
            neg_re_d = n_re[NW-1];
            neg_im_d = n_im[NW-1];
            d_d      = d_now;
            cnt_d    = '0;
            if (d_now == '0) begin
               q_re_d  = '0;
               q_im_d  = '0;
               dz_d    = 1'b1;
               state_d = DONE;
            end else begin
               dz_d    = 1'b0;
               state_d = DIV;
            end
         end
         DIV: begin
            cnt_d = cnt_q + CW'(1);
            // quo_* already include this cycle's bit, so the final step's
            // result is registered on the same edge that enters DONE.
            if (cnt_q == CW'(NITER - 1)) begin
               q_re_d  = neg_re_q ? NW'(-quo_re) : quo_re;
               q_im_d  = neg_im_q ? NW'(-quo_im) : quo_im;
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ar_q     <= '0;
         ai_q     <= '0;
         cr_q     <= '0;
         ci_q     <= '0;
         d_q      <= '0;
         neg_re_q <= 1'b0;
         neg_im_q <= 1'b0;
         q_re_q   <= '0;
         q_im_q   <= '0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ar_q     <= ar_d;
         ai_q     <= ai_d;
         cr_q     <= cr_d;
         ci_q     <= ci_d;
         d_q      <= d_d;
         neg_re_q <= neg_re_d;
         neg_im_q <= neg_im_d;
         q_re_q   <= q_re_d;
         q_im_q   <= q_im_d;
         dz_q     <= dz_d;
      end
   end

   assign q_re     = q_re_q;
   assign q_im     = q_im_q;
   assign div_zero = dz_q;

endmodule

// File: tb/tb_complex_div_seq.sv
// tb/tb_complex_div_seq.sv - self-checking bench for complex_div_seq
module tb_complex_div_seq;
   import cdiv_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic signed [15:0] a_re = '0, a_im = '0, c_re = '0, c_im = '0;
   logic in_ready, out_valid, div_zero;
   logic signed [32:0] q_re, q_im;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   complex_div_seq #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_re      (a_re),
      .a_im      (a_im),
      .c_re      (c_re),
      .c_im      (c_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q_re      (q_re),
      .q_im      (q_im),
      .div_zero  (div_zero)
   );

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: complex quotient from plain integer math, truncating toward zero.
   task automatic model(input longint ar, input longint ai, input longint cr, input longint ci,
                        output longint qr, output longint qi, output bit dz);
      longint nr, ni, d;
      nr = ar * cr + ai * ci;
      ni = ai * cr - ar * ci;
      d  = cr * cr + ci * ci;
      if (d == 0) begin
         qr = 0;
         qi = 0;
         dz = 1'b1;
      end else begin
         qr = nr / d;
         qi = ni / d;
         dz = 1'b0;
      end
   endtask

   task automatic send(input logic signed [15:0] ar, input logic signed [15:0] ai,
                       input logic signed [15:0] cr, input logic signed [15:0] ci);
      int w = 0;
      while (!in_ready && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("in_ready_at_send", in_ready, 1);
      a_re = ar;
      a_im = ai;
      c_re = cr;
      c_im = ci;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag, output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_out_valid"}, out_valid, 1);
   endtask

   task automatic check_q(input string tag, input longint qr, input longint qi, input bit dz);
      chk({tag, "_q_re"}, q_re, qr);
      chk({tag, "_q_im"}, q_im, qi);
      chk({tag, "_div_zero"}, div_zero, dz);
   endtask

   task automatic drain(input bit rnd);
      bit r;
      bit done = 1'b0;
      int w = 0;
      while (!done && w < 200) begin
         r = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         out_ready = r;
         @(posedge clk);
         #1;
         done = r;
         w++;
      end
      out_ready = 1'b0;
      chk("handshake_done", done, 1);
   endtask

   initial begin
      longint eqr, eqi;
      bit edz;
      int lat;
      int k;
      logic signed [15:0] ar, ai, cr, ci;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      check_q("reset", 0, 0, 1'b0);

      // T1 basic
      send(7, 1, 1, 2);
      wait_result("t1", lat);
      chk("t1_latency", lat, 35);
      check_q("t1", 1, -2, 1'b0);
      drain(1'b0);

      // T2 extremes
      send(-32768, -32768, -32768, -32768);
      wait_result("t2a", lat);
      check_q("t2a", 1, 0, 1'b0);
      drain(1'b0);
      send(-32768, -32768, 1, 0);
      wait_result("t2b", lat);
      check_q("t2b", -32768, -32768, 1'b0);
      drain(1'b0);

      // T3 zero divisor, then a normal op clears div_zero
      send(5, 5, 0, 0);
      wait_result("t3", lat);
      chk("t3_latency", lat, 2);
      check_q("t3", 0, 0, 1'b1);
      drain(1'b0);
      send(7, 1, 1, 2);
      wait_result("t3_next", lat);
      check_q("t3_next", 1, -2, 1'b0);
      drain(1'b0);

      // T4 backpressure with a new operand set already offered
      send(7, 1, 1, 2);
      wait_result("t4", lat);
      a_re = 9;
      a_im = 0;
      c_re = 3;
      c_im = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check_q("t4_hold", 1, -2, 1'b0);
         chk("t4_hold_in_ready", in_ready, 0);
         chk("t4_hold_out_valid", out_valid, 1);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("t4_after_hs_in_ready", in_ready, 1);
      chk("t4_after_hs_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("t4_accepted_in_ready", in_ready, 0);
      wait_result("t4_new", lat);
      chk("t4_new_latency", lat, 35);
      check_q("t4_new", 3, 0, 1'b0);
      drain(1'b0);

      // T5 reset during DIV iteration 10
      send(7, 1, 1, 2);
      repeat (11) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t5_out_valid", out_valid, 0);
      chk("t5_in_ready", in_ready, 1);
      check_q("t5_reset", 0, 0, 1'b0);
      send(7, 1, 1, 2);
      wait_result("t5_after", lat);
      check_q("t5_after", 1, -2, 1'b0);
      drain(1'b0);

      // T6 random back-to-back operations
      for (int n = 0; n < 1000; n++) begin
         ar = 16'($urandom);
         ai = 16'($urandom);
         k = int'($urandom_range(0, 9));
         if (k == 0) begin
            cr = '0;
            ci = '0;
         end else if (k < 5) begin
            cr = 16'(int'($urandom_range(0, 16)) - 8);
            ci = 16'(int'($urandom_range(0, 16)) - 8);
         end else begin
            cr = 16'($urandom);
            ci = 16'($urandom);
         end
         model(ar, ai, cr, ci, eqr, eqi, edz);
         send(ar, ai, cr, ci);
         wait_result("t6", lat);
         check_q("t6", eqr, eqi, edz);
         drain(1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
